// File: rtl/seq_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_detector_pkg
//  Purpose  : Shared types and constants for the serial pattern detector.
//             Holds the detector state encoding and the legal PAT_W range.
//  Revision : 1.0  initial release
// ============================================================================
package seq_pattern_detector_pkg;

  // Legal range for the pattern length parameter.
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  // FILL : collecting the first PAT_W-1 bits of history, no match possible.
  // ARMED: history complete, every accepted bit is compared.
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage : seq_pattern_detector_pkg
`default_nettype wire

// File: rtl/seq_pattern_detector_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Saturating up-counter. Counts inc pulses, sticks at all-ones,
//             synchronous clear that takes priority over an increment.
//  Ports    : clk   - clock
//             reset - synchronous active-high reset (count to 0)
//             inc   - increment request
//             clr   - clear request (wins over inc)
//             cnt   - current count, W bits
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_detector
//  Purpose  : Run-time configurable serial pattern detector with a
//             same-cycle (Mealy) match pulse on a valid-qualified 1-bit
//             stream. Pattern and overlap mode are loadable; an optional
//             saturating match counter is available.
//  Build    : SEQ_PATTERN_DETECTOR_COUNT_EN defined   -> match counter and
//             count_clr implemented.
//             SEQ_PATTERN_DETECTOR_COUNT_EN undefined -> match_count tied
//             to 0, count_clr ignored (port list unchanged).
//  Ports    : clk          - clock
//             reset        - synchronous active-high reset
//             in_          - serial data bit
//             in_val       - in_ is valid this cycle
//             cfg_load     - load cfg_pattern / cfg_overlap at next edge
//             cfg_pattern  - new pattern, MSB is the first bit received
//             cfg_overlap  - 1 = overlapping matches, 0 = non-overlapping
//             count_clr    - clear match_count at next edge
//             out          - combinational match pulse
//             match_count  - saturating number of matches
//  Revision : 1.0  initial release
// ============================================================================
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int               PAT_W       = 3,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(3'b101),
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_,
  input  logic             in_val,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  // fill counts 0..PAT_W-1, so clog2(PAT_W) bits are always enough.
  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q,   pat_d;
  logic               ovl_q,   ovl_d;
  logic [PAT_W-2:0]   hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;

  // Candidate window: stored history followed by the bit arriving now.
  logic [PAT_W-1:0]   window;
  logic               match;

  assign window = {hist_q, in_};

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match   = 1'b0;

    if (cfg_load) begin
      // A load restarts collection; the in_ sample of this cycle is dropped.
      pat_d   = cfg_pattern;
      ovl_d   = cfg_overlap;
      fill_d  = '0;
      state_d = FILL;
    end else if (in_val) begin
      // Oldest history bit falls off the top of the window.
      hist_d = window[PAT_W-2:0];
      unique case (state_q)
        FILL: begin
          if (fill_q == FILL_MAX - FILL_W'(1)) begin
            fill_d  = FILL_MAX;
            state_d = ARMED;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        ARMED: begin
          if (window == pat_q) begin
            match = 1'b1;
            // Non-overlapping: matched bits must not contribute to the next
            // match, so history collection starts over.
            if (!ovl_q) begin
              fill_d  = '0;
              state_d = FILL;
            end
          end
        end
        default: begin
          fill_d  = '0;
          state_d = FILL;
        end
      endcase
    end
  end

  // Pulse is suppressed while reset is held.
  assign out = match & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      pat_q   <= DEFAULT_PAT;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out),
    .clr   (count_clr),
    .cnt   (match_count)
  );
`else
  assign match_count = '0;

  logic unused_count_clr;
  assign unused_count_clr = count_clr;
`endif

endmodule : seq_pattern_detector
`default_nettype wire

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector, the next-generation replacement for the fixed 3-bit "101" Mealy detector. The match pattern and overlap mode are run-time loadable, and input bits are qualified by a valid strobe. An optional saturating match counter is provided. It sits on a 1-bit serial stream and emits a same-cycle, Mealy-style match pulse.

## Interface
Parameters:
- PAT_W, default 3: pattern length in bits; legal range 2..16.
- DEFAULT_PAT, default 3'b101 (PAT_W bits): pattern loaded at reset.
- CNT_W, default 8: match counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_  input  1  serial data bit.
- in_val  input  1  in_ is valid this cycle.
- cfg_load  input  1  load cfg_pattern/cfg_overlap at the next edge.
- cfg_pattern  input  PAT_W  new pattern; MSB is the first bit received.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- count_clr  input  1  clear match_count at the next edge.
- out  output  1  match pulse (combinational).
- match_count  output  CNT_W  saturating number of matches.

## Operation
- Registers:
  - pat: PAT_W bits.
  - ovl: 1 bit.
  - hist: the last PAT_W-1 accepted bits, newest at LSB.
  - fill: count of valid hist bits, 0..PAT_W-1.
  - state.
- State FILL: fill < PAT_W-1. out = 0. On in_val, hist shifts in in_ and fill increments. FILL moves to ARMED when fill reaches PAT_W-1.
- State ARMED: out = in_val & ({hist, in_} == pat). On in_val, hist shifts in in_.
- On a match in ARMED:
  - ovl = 1: remain in ARMED, keep shifting.
  - ovl = 0: clear fill to 0 and return to FILL. The matched bits are not reused.
- in_val = 0: no state or register change; out = 0.
- cfg_load: at the next edge, pat <= cfg_pattern, ovl <= cfg_overlap, fill <= 0, state <= FILL.
- cfg_load has priority over in_val. In a cfg_load cycle, out = 0 and the in_ sample is discarded.
- match_count increments by 1 on every cycle with out = 1. It saturates at 2^CNT_W-1 and does not wrap.
- If count_clr and a match occur in the same cycle, the clear wins: match_count becomes 0.
- Reset applies these values:
  - pat = DEFAULT_PAT, ovl = 1, hist = 0, fill = 0, state = FILL.
  - match_count = 0; out = 0 while reset is high.
- Reset mid-stream discards the partial history. Post-reset behaviour with default parameters is identical to the legacy 101 overlapping detector.

## Timing
- out: zero latency; combinational from state, hist, pat, in_ and in_val.
- Register updates: all on the posedge of clk.
- New configuration: effective for the first in_val bit after the load edge. At least PAT_W accepted bits are needed before the first possible match.
- match_count: reflects a match one cycle after the out pulse.
- Match rate: at most one match per cycle with ovl = 1; at most one per PAT_W accepted bits with ovl = 0.
- Gapped input: gaps in in_val stretch the timing but never alter the matching result.

## Configuration
- Macro SEQ_PATTERN_DETECTOR_COUNT_EN, defined: the match counter and count_clr are implemented as described.
- Macro undefined: no counter register; match_count is tied to 0 and count_clr is ignored. The port list is unchanged.

## Structure
- Package seq_pattern_detector_pkg contains:
  - the state enum typedef (FILL, ARMED);
  - the PAT_W legal-range constants.
- Sub-module sat_counter (parameter W; inputs inc, clr; output cnt; clr wins) implements match_count. It is instantiated only under SEQ_PATTERN_DETECTOR_COUNT_EN.

## Test plan
- Defaults after reset, in_val=1, stream 1,0,1,0,1 -> out=1 on the 3rd and 5th bits; match_count=2.
- cfg_load pattern=1101, ovl=0 (PAT_W=4 build), stream 1,1,0,1,1,0,1 -> out=1 on the 4th bit only.
- Same stream with ovl=1 -> out=1 on the 4th and 7th bits.
- Defaults, stream 1,0,1 with in_val deasserted for 3 cycles between bits -> exactly one match, on the 3rd valid bit. out=0 in all idle cycles.
- cfg_load and in_val=1 in the same cycle, mid-pattern -> out=0 that cycle, history cleared, next match only after PAT_W new bits. Reset asserted after the 2 bits 1,0 -> following in_=1 gives no match.
- CNT_W=2, six matches -> match_count sticks at 3. count_clr in the same cycle as a match -> match_count=0. Macro undefined -> match_count stays 0 throughout.
